// File: rtl/po2_net_pkg.sv
// Shared types and fixed-point helpers for the po2 neuron datapath.
// Width-generic helpers work on a MAX_AW container; callers slice to their width.
package po2_net_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    BIAS   = 2'd2,
    NARROW = 2'd3
  } state_e;

  localparam int unsigned MAX_AW = 128;

  // Sign-extend the low src_w bits of x across the whole container.
  function automatic logic signed [MAX_AW-1:0] sext_acc(input logic [MAX_AW-1:0] x,
                                                         input int unsigned src_w);
    logic signed [MAX_AW-1:0] t;
    t = x << (MAX_AW - src_w);
    return t >>> (MAX_AW - src_w);
  endfunction

  // Single-width Q(I).(W-I) to double-width Q(2I).(2W-2I), sign-extended.
  function automatic logic signed [MAX_AW-1:0] pad_to_double(input logic [MAX_AW-1:0] x,
                                                              input int unsigned w,
                                                              input int unsigned i);
    return sext_acc(x, w) <<< (w - i);
  endfunction

endpackage

// File: rtl/po2_narrow_sat.sv
// Combinational narrowing of the AW-bit accumulator to a saturated W-bit Q(I).(W-I).
// Build option: PO2_ACC_RELU_EN clamps any negative sum to zero without flagging saturation.
module po2_narrow_sat
  import po2_net_pkg::*;
#(
  parameter int W  = 16,
  parameter int I  = 4,
  parameter int AW = 37
) (
  input  logic [AW-1:0] i_acc,
  output logic [W-1:0]  o_value,
  output logic          o_sat
);

  localparam int LSB = W - I;
  localparam int MSB = 2 * W - I - 1;

  logic              w_sign;
  logic              w_fits;
  logic [AW-1-MSB:0] w_upper;
  logic              w_unused_frac;

  assign w_sign        = i_acc[AW-1];
  assign w_upper       = i_acc[AW-1:MSB];
  assign w_fits        = (w_upper == '0) || (w_upper == '1);
  // Fraction bits below the kept window are dropped: truncation toward -inf.
  assign w_unused_frac = ^i_acc[LSB-1:0];

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    o_value = i_acc[MSB:LSB];
    o_sat   = 1'b0;
`ifdef PO2_ACC_RELU_EN
    if (w_sign) begin
      o_value = '0;
    end else if (!w_fits) begin
      o_value = {1'b0, {(W-1){1'b1}}};
      o_sat   = 1'b1;
    end
`else
    if (!w_fits) begin
      o_value = w_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      o_sat   = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/po2_dot_accumulate.sv
// Accumulates N double-width po2 products plus a bias and emits a saturated W-bit activation.
// Build option: PO2_ACC_RELU_EN (fused ReLU in the narrowing stage, see po2_narrow_sat).
module po2_dot_accumulate
  import po2_net_pkg::*;
#(
  parameter int W = 16,
  parameter int I = 4,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bias,
  input  logic [2*W-1:0] prod_in,
  input  logic           prod_v,
  output logic [W-1:0]   out,
  output logic           out_v,
  output logic           saturated,
  output logic           busy,
  output logic           prod_drop
);

  // Guard bits cover N full-scale products plus the bias without wrapping.
  localparam int AW = 2 * W + $clog2(N) + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e               r_state;
  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_count;
  logic [W-1:0]         r_bias;
  logic [W-1:0]         r_out;
  logic                 r_out_v;
  logic                 r_sat;
  logic                 r_prod_drop;

  logic signed [MAX_AW-1:0] w_prod_full;
  logic signed [MAX_AW-1:0] w_bias_full;
  logic signed [AW-1:0]     w_prod_ext;
  logic signed [AW-1:0]     w_bias_ext;
  logic [W-1:0]             w_nar_val;
  logic                     w_nar_sat;

  assign w_prod_full = sext_acc(MAX_AW'(prod_in), 2 * W);
  assign w_bias_full = pad_to_double(MAX_AW'(r_bias), W, I);
  assign w_prod_ext  = w_prod_full[AW-1:0];
  assign w_bias_ext  = w_bias_full[AW-1:0];

  po2_narrow_sat #(
    .W  (W),
    .I  (I),
    .AW (AW)
  ) u_narrow (
    .i_acc   (r_acc),
    .o_value (w_nar_val),
    .o_sat   (w_nar_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_bias      <= '0;
      r_out       <= '0;
      r_out_v     <= 1'b0;
      r_sat       <= 1'b0;
      r_prod_drop <= 1'b0;
    end else begin
      r_out_v <= 1'b0;
      if (prod_v && (r_state != ACCUM)) r_prod_drop <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_bias      <= bias;
            r_prod_drop <= prod_v;
            r_state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (prod_v) begin
            r_acc   <= r_acc + w_prod_ext;
            r_count <= r_count + 1'b1;
            if (r_count == CW'(N - 1)) r_state <= BIAS;
          end
        end
        BIAS: begin
          r_acc   <= r_acc + w_bias_ext;
          r_state <= NARROW;
        end
        NARROW: begin
          r_out   <= w_nar_val;
          r_sat   <= w_nar_sat;
          r_out_v <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out       = r_out;
  assign out_v     = r_out_v;
  assign saturated = r_sat;
  assign busy      = (r_state != IDLE);
  assign prod_drop = r_prod_drop;

endmodule

// File: tb/tb_po2_dot_accumulate.sv
// Scoreboard bench for po2_dot_accumulate: one N=4 and one N=8 instance, W=16, I=4.
// Define PO2_ACC_RELU_EN for both bench and RTL to exercise the fused-ReLU build.
`timescale 1ns/1ps
module tb_po2_dot_accumulate;

  typedef struct packed {
    logic [15:0] v;
    logic        s;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: N=4
  logic        a_start = 1'b0;
  logic [15:0] a_bias  = '0;
  logic [31:0] a_prod  = '0;
  logic        a_pv    = 1'b0;
  logic [15:0] a_out;
  logic        a_out_v, a_sat, a_busy, a_drop;
  // Instance B: N=8
  logic        b_start = 1'b0;
  logic [15:0] b_bias  = '0;
  logic [31:0] b_prod  = '0;
  logic        b_pv    = 1'b0;
  logic [15:0] b_out;
  logic        b_out_v, b_sat, b_busy, b_drop;

  po2_dot_accumulate #(.W(16), .I(4), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .bias(a_bias), .prod_in(a_prod),
    .prod_v(a_pv), .out(a_out), .out_v(a_out_v), .saturated(a_sat),
    .busy(a_busy), .prod_drop(a_drop)
  );

  po2_dot_accumulate #(.W(16), .I(4), .N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .bias(b_bias), .prod_in(b_prod),
    .prod_v(b_pv), .out(b_out), .out_v(b_out_v), .saturated(b_sat),
    .busy(b_busy), .prod_drop(b_drop)
  );

  res_t exp_q [2][$];
  res_t obs_q [2][$];
  int   obs_c [2][$];
  int   last_c [2];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    if (a_out_v) begin obs_q[0].push_back('{v: a_out, s: a_sat}); obs_c[0].push_back(cyc); end
    if (b_out_v) begin obs_q[1].push_back('{v: b_out, s: b_sat}); obs_c[1].push_back(cyc); end
  end

  // Reference: exact sum, floor-shift to Q4.12, then clamp.
  function automatic res_t model(input longint sum_d, input logic [15:0] b);
    longint s, r;
    res_t   x;
    s = sum_d + (longint'($signed(b)) <<< 12);
    r = s >>> 12;
`ifdef PO2_ACC_RELU_EN
    if (s < 0) return '{v: 16'h0000, s: 1'b0};
`endif
    if (r > 32767)       x = '{v: 16'h7FFF, s: 1'b1};
    else if (r < -32768) x = '{v: 16'h8000, s: 1'b1};
    else                 x = '{v: 16'(r), s: 1'b0};
    return x;
  endfunction

  task automatic drive_start(input bit sel, input logic [15:0] bv);
    if (sel) begin b_start = 1'b1; b_bias = bv; end
    else     begin a_start = 1'b1; a_bias = bv; end
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic drive_prod(input bit sel, input logic [31:0] p);
    if (sel) begin b_pv = 1'b1; b_prod = p; end
    else     begin a_pv = 1'b1; a_prod = p; end
    @(posedge clk); #1;
    a_pv = 1'b0;
    b_pv = 1'b0;
    last_c[sel] = cyc;
  endtask

  task automatic check_result(input bit sel, input string name, input bit chk_lat);
    res_t e, o;
    int   oc, k;
    n_checks++;
    if (exp_q[sel].size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q[sel].pop_front();
    k = 0;
    while (obs_q[sel].size() == 0 && k < 20) begin @(negedge clk); k++; end
    if (obs_q[sel].size() == 0) begin
      n_fail++;
      $display("FAIL %s: no out_v within 20 cycles, expected out=%h", name, e.v);
      return;
    end
    o  = obs_q[sel].pop_front();
    oc = obs_c[sel].pop_front();
    n_checks++;
    if (o.v !== e.v) begin
      n_fail++;
      $display("FAIL %s out: got %h expected %h", name, o.v, e.v);
    end
    n_checks++;
    if (o.s !== e.s) begin
      n_fail++;
      $display("FAIL %s saturated: got %b expected %b", name, o.s, e.s);
    end
    if (chk_lat) begin
      n_checks++;
      if (oc != last_c[sel] + 2) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected 2 edges", name, oc - last_c[sel]);
      end
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (a_out !== 16'h0000) begin n_fail++; $display("FAIL reset out: got %h expected 0000", a_out); end
    expect_bit("reset out_v", a_out_v, 1'b0);
    expect_bit("reset saturated", a_sat, 1'b0);
    expect_bit("reset busy", a_busy, 1'b0);
    expect_bit("reset prod_drop", a_drop, 1'b0);
    expect_bit("reset busy n8", b_busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    exp_q[0].push_back('{v: 16'h2000, s: 1'b0});
    drive_start(1'b0, 16'h0000);
    expect_bit("basic busy", a_busy, 1'b1);
    repeat (4) drive_prod(1'b0, 32'h0080_0000);
    check_result(1'b0, "basic_4x0.5", 1'b1);
    exp_q[0].push_back('{v: 16'h0000, s: 1'b0});
    drive_start(1'b0, 16'hF000);
    repeat (4) drive_prod(1'b0, 32'h0040_0000);
    check_result(1'b0, "bias_neg1", 1'b1);
  endtask

  task automatic test_saturate();
    exp_q[1].push_back('{v: 16'h7FFF, s: 1'b1});
    drive_start(1'b1, 16'h0000);
    repeat (8) drive_prod(1'b1, 32'h0400_0000);
    check_result(1'b1, "sat_pos", 1'b1);
`ifdef PO2_ACC_RELU_EN
    exp_q[1].push_back('{v: 16'h0000, s: 1'b0});
`else
    exp_q[1].push_back('{v: 16'h8000, s: 1'b1});
`endif
    drive_start(1'b1, 16'h0000);
    repeat (8) drive_prod(1'b1, 32'hFC00_0000);
    check_result(1'b1, "sat_neg", 1'b1);
  endtask

  task automatic test_reset_mid();
    drive_start(1'b0, 16'h0000);
    repeat (2) drive_prod(1'b0, 32'h0100_0000);
    rst_n = 1'b0;
    #1;
    expect_bit("midrst busy", a_busy, 1'b0);
    expect_bit("midrst out_v", a_out_v, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q[0].size() != 0) begin
      n_fail++;
      $display("FAIL midrst stray out_v: got %0d results expected 0", obs_q[0].size());
    end
    exp_q[0].push_back('{v: 16'h4000, s: 1'b0});
    drive_start(1'b0, 16'h0000);
    repeat (4) drive_prod(1'b0, 32'h0100_0000);
    check_result(1'b0, "after_reset", 1'b1);
  endtask

  task automatic test_drop();
    drive_prod(1'b0, 32'h0100_0000);
    expect_bit("drop set in idle", a_drop, 1'b1);
    expect_bit("drop idle stays idle", a_busy, 1'b0);
    exp_q[0].push_back('{v: 16'h2000, s: 1'b0});
    drive_start(1'b0, 16'h0000);
    expect_bit("drop cleared by start", a_drop, 1'b0);
    repeat (2) drive_prod(1'b0, 32'h0080_0000);
    drive_start(1'b0, 16'h1000);
    expect_bit("start in accum busy", a_busy, 1'b1);
    expect_bit("accum no drop", a_drop, 1'b0);
    repeat (2) drive_prod(1'b0, 32'h0080_0000);
    check_result(1'b0, "start_ignored", 1'b1);
  endtask

  task automatic test_relu_sign();
`ifdef PO2_ACC_RELU_EN
    exp_q[0].push_back('{v: 16'h0000, s: 1'b0});
`else
    exp_q[0].push_back('{v: 16'hE000, s: 1'b0});
`endif
    drive_start(1'b0, 16'h0000);
    repeat (4) drive_prod(1'b0, 32'hFF80_0000);
    check_result(1'b0, "neg_half_x4", 1'b1);
  endtask

  task automatic test_back_to_back();
    bit seen;
    exp_q[0].push_back('{v: 16'h2000, s: 1'b0});
    drive_start(1'b0, 16'h0000);
    repeat (4) drive_prod(1'b0, 32'h0080_0000);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      seen = a_out_v;
    end
    expect_bit("b2b out_v seen", seen, 1'b1);
    exp_q[0].push_back('{v: 16'h5000, s: 1'b0});
    drive_start(1'b0, 16'h1000);
    expect_bit("b2b start accepted", a_busy, 1'b1);
    check_result(1'b0, "b2b_first", 1'b1);
    repeat (4) drive_prod(1'b0, 32'h0100_0000);
    check_result(1'b0, "b2b_second", 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      longint      sum;
      logic [15:0] b;
      int          p [4];
      sum = 0;
      b   = 16'($urandom);
      for (int j = 0; j < 4; j++) begin
        p[j] = int'($urandom_range(67108864)) - 33554432;
        sum += longint'(p[j]);
      end
      exp_q[0].push_back(model(sum, b));
      drive_start(1'b0, b);
      for (int j = 0; j < 4; j++) drive_prod(1'b0, 32'(p[j]));
      check_result(1'b0, $sformatf("random_%0d", t), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_reset_mid();
    test_drop();
    test_relu_sign();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
